alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised successor to the datapath ALU.
- Single-cycle integer ops are registered. RV32M-style multiply/divide/remainder run iteratively, one bit per cycle.
- Sits in the execute stage. Uses a valid/ready handshake on input and output, so the pipeline stalls on busy.
- Shift amounts come from the low SrcB bits, with no offset encoding.

Parameters:
- DATA_WIDTH, 32, operand/result width W; power of two, ≥8.
- OPCODE_LENGTH, 5, Operation width. Bit 4 = 0 selects base ops; bit 4 = 1 selects M ops.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), number of SrcB bits used as shift amount.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept this cycle.
- Operation  input  OPCODE_LENGTH  op select.
- SrcA  input  DATA_WIDTH  operand A (rs1).
- SrcB  input  DATA_WIDTH  operand B (rs2/imm).
- flush  input  1  abort in-flight op (branch mispredict/trap).
- out_valid  output  1  ALUResult valid.
- out_ready  input  1  consumer takes result.
- ALUResult  output  DATA_WIDTH  registered result.
- busy  output  1  state != IDLE.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state=IDLE; out_valid=0; ALUResult=0; busy=0; iteration counter=0. in_ready=1 from the first cycle after reset deasserts. Reset mid-operation discards all state identically.
- Accept: occurs on a clk edge where in_valid && in_ready. Operands and opcode are captured; later input changes are ignored.
- in_ready = (state==IDLE). No new accept while CALC/FIX/DONE.
- Base ops, all signed compares two's complement, result 1/0 zero-extended:
  - 00000 AND; 00001 XOR; 00010 SUB; 00011 OR; 00100 ADD
  - 00101 GE signed; 00110 NE; 00111 SRA; 01000 EQ; 01001 SLL
  - 01010 PASSB; 01011 LTU; 01100 SRL; 01101 LT signed; 01110 SLT signed; 01111 GEU
  - Shifts use SrcB[SHAMT_WIDTH-1:0].
- M ops:
  - 10000 MUL (low W bits)
  - 10001 MULH (s×s high); 10010 MULHSU (s×u high); 10011 MULHU (u×u high)
  - 10100 DIV; 10101 DIVU; 10110 REM; 10111 REMU
  - Undefined opcode: result 0, single-cycle path.
- State machine IDLE/CALC/FIX/DONE:
  - IDLE --accept base op--> DONE. out_valid=1 the cycle after accept (latency 1).
  - IDLE --accept M op--> CALC. Operands are converted to magnitudes per signedness and the counter is loaded with W.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements. At counter==1 the step completes → FIX.
  - FIX: apply result sign (product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA) and select high/low half → DONE.
  - M-op latency is fixed: out_valid rises exactly W+2 cycles after accept, including the special cases below.
  - DONE: out_valid=1; ALUResult held stable. On out_ready → IDLE (out_valid=0 next cycle). out_ready is ignored in other states.
- Divide special cases, fixed latency preserved:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = dividend.
  - DIV with most-negative / -1 = most-negative; REM = 0.
- flush:
  - In CALC/FIX/DONE: → IDLE next edge, out_valid=0, result discarded.
  - In IDLE it blocks accept that cycle, and in_ready is still reported 1.
  - reset has priority over flush.
- Product datapath: 2W-bit accumulator. Divider uses a W+1-bit partial remainder; no truncation before FIX.

Test Plan:
- W=32. ADD SrcA=5 SrcB=7 accepted at cycle t → out_valid=1 at t+1, ALUResult=12; with out_ready=1, in_ready=1 at t+2.
- MULH 0x80000000×0x80000000 → 0x40000000 at exactly t+34. Also MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. Also MULHU of the same operands → 0xFFFFFFFE.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Also DIV -7/2 → 0xFFFFFFFD (-3) and REM → 0xFFFFFFFF (-1); latency t+34 in all cases.
- DIVU 13/0 → 0xFFFFFFFF; REMU 13/0 → 13; DIV -5/0 → 0xFFFFFFFF.
- Backpressure and abort:
  - MUL completes with out_ready=0 for 5 cycles → ALUResult stable, in_ready=0 throughout; one cycle of out_ready → IDLE.
  - Separately, flush at CALC cycle 10 → IDLE next cycle, out_valid never asserts.
  - reset asserted mid-CALC → all outputs at reset values the next cycle.
- SRA 0xF0000000 by SrcB=0x24 (shamt 4) → 0xFF000000. Also SLT 0xFFFFFFFF<1 → 1, LTU same operands → 0, and undefined opcode 11111 → 0 at t+1.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with registered single-cycle ops
// and iterative RV32M-style multiply/divide behind a valid/ready handshake.
module alu_multicycle #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 5,
   parameter int SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     busy
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic [2:0]     op_q;
   logic [W-1:0]   ma;
   logic [W-1:0]   mb;
   logic [2*W-1:0] acc;
   logic [W:0]     rem;
   logic [W-1:0]   a_raw;
   logic           sa;
   logic           sb;
   logic           div0;

   logic [SHAMT_WIDTH-1:0] shamt;
   logic [W-1:0]   base_res;
   logic           m_op;
   logic           undef_op;
   logic           accept;
   logic           sa_in;
   logic           sb_in;
   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;

   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_nxt;
   logic [W:0]     div_sh;
   logic [W+1:0]   div_diff;
   logic           div_ok;
   logic [W:0]     rem_nxt;

   logic [2*W-1:0] prod;
   logic [W-1:0]   q_s;
   logic [W-1:0]   r_s;
   logic [W-1:0]   fix_res;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign shamt    = SrcB[SHAMT_WIDTH-1:0];
   assign m_op     = Operation[4] & ~Operation[3];
   assign undef_op = Operation[4] & Operation[3];
   assign accept   = in_valid & in_ready & ~flush;

   // Single-cycle base operation result from the live inputs
   always_comb begin
      base_res = '0;
      case (Operation[3:0])
         4'h0: base_res = SrcA & SrcB;
         4'h1: base_res = SrcA ^ SrcB;
         4'h2: base_res = SrcA - SrcB;
         4'h3: base_res = SrcA | SrcB;
         4'h4: base_res = SrcA + SrcB;
         4'h5: base_res = W'($signed(SrcA) >= $signed(SrcB));
         4'h6: base_res = W'(SrcA != SrcB);
         4'h7: base_res = $signed(SrcA) >>> shamt;
         4'h8: base_res = W'(SrcA == SrcB);
         4'h9: base_res = SrcA << shamt;
         4'hA: base_res = SrcB;
         4'hB: base_res = W'(SrcA < SrcB);
         4'hC: base_res = SrcA >> shamt;
         4'hD: base_res = W'($signed(SrcA) < $signed(SrcB));
         4'hE: base_res = W'($signed(SrcA) < $signed(SrcB));
         4'hF: base_res = W'(SrcA >= SrcB);
         default: base_res = '0;
      endcase
   end

   // Operand signedness and magnitudes for the M-op datapath
   always_comb begin
      sa_in = 1'b0;
      sb_in = 1'b0;
      case (Operation[2:0])
         3'b001: begin sa_in = SrcA[W-1]; sb_in = SrcB[W-1]; end
         3'b010: sa_in = SrcA[W-1];
         3'b100: begin sa_in = SrcA[W-1]; sb_in = SrcB[W-1]; end
         3'b110: begin sa_in = SrcA[W-1]; sb_in = SrcB[W-1]; end
         default: begin sa_in = 1'b0; sb_in = 1'b0; end
      endcase
      mag_a = sa_in ? -SrcA : SrcA;
      mag_b = sb_in ? -SrcB : SrcB;
   end

   // One shift-add or restoring-subtract step
   always_comb begin
      mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, ma} : '0);
      mul_nxt  = {mul_sum, acc[W-1:1]};
      div_sh   = {rem[W-1:0], acc[W-1]};
      div_diff = {1'b0, div_sh} - {2'b00, mb};
      div_ok   = ~div_diff[W+1];
      rem_nxt  = div_ok ? div_diff[W:0] : div_sh;
   end

   // Sign fix-up, half select and divide-by-zero override
   always_comb begin
      prod    = (sa ^ sb) ? -acc : acc;
      q_s     = (sa ^ sb) ? -acc[W-1:0] : acc[W-1:0];
      r_s     = sa ? -rem[W-1:0] : rem[W-1:0];
      if (div0) begin
         q_s = '1;
         r_s = a_raw;
      end
      if (op_q[2])
         fix_res = op_q[1] ? r_s : q_s;
      else if (op_q[1:0] == 2'b00)
         fix_res = prod[W-1:0];
      else
         fix_res = prod[2*W-1:W];
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         ALUResult <= '0;
         op_q      <= '0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         div0      <= 1'b0;
      end else if (flush && state != IDLE) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q <= Operation[2:0];
               if (m_op) begin
                  state <= CALC;
                  cnt   <= CW'(W);
                  sa    <= sa_in;
                  sb    <= sb_in;
                  ma    <= mag_a;
                  mb    <= mag_b;
                  acc   <= {{W{1'b0}}, Operation[2] ? mag_a : mag_b};
                  rem   <= '0;
                  a_raw <= SrcA;
                  div0  <= (SrcB == '0);
               end else begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  ALUResult <= undef_op ? '0 : base_res;
               end
            end
            CALC: begin
               if (op_q[2]) begin
                  acc[W-1:0] <= {acc[W-2:0], div_ok};
                  rem        <= rem_nxt;
               end else begin
                  acc <= mul_nxt;
               end
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1))
                  state <= FIX;
            end
            FIX: begin
               ALUResult <= fix_res;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle at W=32.
// Expected results are queued at accept and popped when out_valid rises.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   alu_multicycle dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one request at a negedge; returns in the cycle after accept.
   task automatic issue(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
      @(posedge clk);
      sb_q.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
      SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; Operation = 5'h0;
   endtask

   // Wait for out_valid, check latency and the popped expected result.
   task automatic collect(input string tag, input int lat);
      int n = 1;
      logic [31:0] e;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_lat"}, n, lat);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hXXXX_XXXX;
      chk(tag, ALUResult, e);
   endtask

   task automatic run(input string tag, input logic [4:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat);
      issue(op, a, b, exp);
      collect(tag, lat);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] held;
      int seen;
      reset = 1'b1; in_valid = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;
      flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", ALUResult, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      issue(5'b00100, 32'd5, 32'd7, 32'd12);
      collect("add", 1);
      @(negedge clk);
      chk("add_in_ready_t2", 32'(in_ready), 1);

      run("sra", 5'b00111, 32'hF000_0000, 32'h24, 32'hFF00_0000, 1);
      run("slt", 5'b01110, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
      run("ltu", 5'b01011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
      run("undef", 5'b11111, 32'h1234, 32'h5678, 32'd0, 1);
      run("sub", 5'b00010, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
      run("sll", 5'b01001, 32'h1, 32'h3F, 32'h8000_0000, 1);
      run("geu", 5'b01111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);

      run("mulh", 5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run("mul", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
      run("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      run("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
      run("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
      run("div_neg", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run("divu_0", 5'b10101, 32'd13, 32'd0, 32'hFFFF_FFFF, 34);
      run("remu_0", 5'b10111, 32'd13, 32'd0, 32'd13, 34);
      run("div_0", 5'b10100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 34);
      run("divu", 5'b10101, 32'd100, 32'd7, 32'd14, 34);
      run("remu", 5'b10111, 32'd100, 32'd7, 32'd2, 34);

      out_ready = 1'b0;
      issue(5'b10000, 32'd6, 32'd7, 32'd42);
      collect("mul_bp", 34);
      held = ALUResult;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_stable", ALUResult, 32'd42);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_valid", 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_release_valid", 32'(out_valid), 0);
      chk("bp_release_ready", 32'(in_ready), 1);
      chk("bp_held", held, 32'd42);
      out_ready = 1'b1;

      issue(5'b10100, 32'd1000, 32'd3, 32'd333);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      void'(sb_q.pop_back());
      chk("flush_busy", 32'(busy), 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_ready", 32'(in_ready), 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("flush_no_valid", seen, 0);

      Operation = 5'b00100; SrcA = 32'd1; SrcB = 32'd1;
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_busy", 32'(busy), 0);
      chk("idle_flush_valid", 32'(out_valid), 0);

      issue(5'b10000, 32'd3, 32'd5, 32'd15);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      void'(sb_q.pop_back());
      chk("rst_mid_valid", 32'(out_valid), 0);
      chk("rst_mid_result", ALUResult, 0);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_ready", 32'(in_ready), 1);
      reset = 1'b0;
      @(negedge clk);

      run("post_rst_add", 5'b00100, 32'd40, 32'd2, 32'd42, 1);
      chk("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
